// File: rtl/pci_master_if.sv
// PCI initiator: requests the bus, runs one address phase plus a 1..MAX_BURST
// data-phase burst with IRDY/TRDY handshaking, DEVSEL timeout and bus release.
module pci_master_if #(
  parameter int unsigned MAX_BURST      = 8,
  parameter int unsigned DEVSEL_TIMEOUT = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  cmd,
  input  logic [31:0] addr,
  input  logic [3:0]  nwords,
  input  logic [31:0] wdata,
  output logic        wr_pop,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        busy,
  output logic        done,
  output logic        abort,
  output logic        REQ,
  input  logic        GNT,
  input  logic        bus_frame,
  input  logic        bus_irdy,
  output logic        FRAME,
  output logic        IRDY,
  input  logic        TRDY,
  input  logic        DEVSEL,
  output logic [31:0] AD_out,
  input  logic [31:0] AD_in,
  output logic [3:0]  CBE,
  output logic        drive_en
);

  localparam int unsigned CNT_W = $clog2(DEVSEL_TIMEOUT + 1);
  localparam int unsigned NW_W  = 4;

  typedef enum logic [2:0] {IDLE, REQ_WAIT, ADDR, DATA, TURNAR, ABORT} state_t;

  state_t            state_q, state_d;
  logic              req_q, req_d;
  logic              frame_q, frame_d;
  logic              irdy_q, irdy_d;
  logic              drive_q, drive_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              abort_q, abort_d;
  logic              rdv_q, rdv_d;
  logic [31:0]       rd_data_q, rd_data_d;
  logic [31:0]       ad_q, ad_d;
  logic [31:0]       addr_q, addr_d;
  logic [3:0]        cbe_q, cbe_d;
  logic [3:0]        cmd_q, cmd_d;
  logic [NW_W-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]  dcnt_q, dcnt_d;
  logic              dseen_q, dseen_d;

  logic nwords_ok;
  logic is_write;
  logic xfer;

  assign nwords_ok = (nwords != '0) && (32'(nwords) <= MAX_BURST);
  assign is_write  = cmd_q[0];
  assign xfer      = (state_q == DATA) && !irdy_q && !TRDY;

  // Write data goes straight from the local side onto AD during data phases
  assign wr_pop   = xfer && is_write;
  assign AD_out   = ((state_q == DATA) && is_write) ? wdata : ad_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rdv_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign abort    = abort_q;
  assign REQ      = req_q;
  assign FRAME    = frame_q;
  assign IRDY     = irdy_q;
  assign CBE      = cbe_q;
  assign drive_en = drive_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      req_q     <= 1'b1;
      frame_q   <= 1'b1;
      irdy_q    <= 1'b1;
      drive_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
      rdv_q     <= 1'b0;
      rd_data_q <= '0;
      ad_q      <= '0;
      addr_q    <= '0;
      cbe_q     <= '0;
      cmd_q     <= '0;
      rem_q     <= '0;
      dcnt_q    <= '0;
      dseen_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      frame_q   <= frame_d;
      irdy_q    <= irdy_d;
      drive_q   <= drive_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      abort_q   <= abort_d;
      rdv_q     <= rdv_d;
      rd_data_q <= rd_data_d;
      ad_q      <= ad_d;
      addr_q    <= addr_d;
      cbe_q     <= cbe_d;
      cmd_q     <= cmd_d;
      rem_q     <= rem_d;
      dcnt_q    <= dcnt_d;
      dseen_q   <= dseen_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    frame_d   = frame_q;
    irdy_d    = irdy_q;
    drive_d   = drive_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    abort_d   = 1'b0;
    rdv_d     = 1'b0;
    rd_data_d = rd_data_q;
    ad_d      = ad_q;
    addr_d    = addr_q;
    cbe_d     = cbe_q;
    cmd_d     = cmd_q;
    rem_d     = rem_q;
    dcnt_d    = dcnt_q;
    dseen_d   = dseen_q;

    case (state_q)
      IDLE: begin
        if (start && nwords_ok) begin
          cmd_d   = cmd;
          addr_d  = addr;
          rem_d   = nwords;
          req_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = REQ_WAIT;
        end
      end

      REQ_WAIT: begin
        if (!GNT && bus_frame && bus_irdy) begin
          frame_d = 1'b0;
          ad_d    = addr_q;
          cbe_d   = cmd_q;
          drive_d = 1'b1;
          req_d   = 1'b1;
          state_d = ADDR;
        end
      end

      ADDR: begin
        irdy_d  = 1'b0;
        cbe_d   = '0;
        dcnt_d  = '0;
        dseen_d = 1'b0;
        if (rem_q == NW_W'(1)) frame_d = 1'b1;
        state_d = DATA;
      end

      DATA: begin
        if (!DEVSEL) dseen_d = 1'b1;
        if (xfer) begin
          rem_d = rem_q - NW_W'(1);
          if (!is_write) begin
            rd_data_d = AD_in;
            rdv_d     = 1'b1;
          end
          // FRAME goes high while the final data phase is still pending
          if (rem_q == NW_W'(2)) frame_d = 1'b1;
          if (rem_q == NW_W'(1)) begin
            irdy_d  = 1'b1;
            state_d = TURNAR;
          end
        end else if (DEVSEL && !dseen_q) begin
          if (dcnt_q == CNT_W'(DEVSEL_TIMEOUT - 1)) begin
            frame_d = 1'b1;
            state_d = ABORT;
          end else begin
            dcnt_d = dcnt_q + CNT_W'(1);
          end
        end
      end

      TURNAR: begin
        drive_d = 1'b0;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      ABORT: begin
        irdy_d  = 1'b1;
        drive_d = 1'b0;
        abort_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pci_master_if.sv
// Self-checking bench for pci_master_if: scripted target/arbiter per scenario,
// read/write data checked through expected-word queues.
module tb_pci_master_if;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  cmd;
  logic [31:0] addr;
  logic [3:0]  nwords;
  logic [31:0] wdata;
  logic        wr_pop;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        busy;
  logic        done;
  logic        abort;
  logic        REQ;
  logic        GNT;
  logic        bus_frame;
  logic        bus_irdy;
  logic        FRAME;
  logic        IRDY;
  logic        TRDY;
  logic        DEVSEL;
  logic [31:0] AD_out;
  logic [31:0] AD_in;
  logic [3:0]  CBE;
  logic        drive_en;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int abort_cnt = 0;
  int widx     = 0;
  logic pop_pend = 1'b0;

  logic [31:0] wq[$];
  logic [31:0] rq[$];

  pci_master_if #(.MAX_BURST(8), .DEVSEL_TIMEOUT(5)) dut (
    .clk(clk), .rst(rst), .start(start), .cmd(cmd), .addr(addr), .nwords(nwords),
    .wdata(wdata), .wr_pop(wr_pop), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .done(done), .abort(abort), .REQ(REQ), .GNT(GNT),
    .bus_frame(bus_frame), .bus_irdy(bus_irdy), .FRAME(FRAME), .IRDY(IRDY),
    .TRDY(TRDY), .DEVSEL(DEVSEL), .AD_out(AD_out), .AD_in(AD_in), .CBE(CBE),
    .drive_en(drive_en)
  );

  always #5 clk = ~clk;

  // Local write source: next word appears the cycle after an accepted word
  assign wdata = 32'hCAFE_0000 + 32'(widx);
  always @(negedge clk) pop_pend <= wr_pop;
  always @(posedge clk) if (pop_pend) widx <= widx + 1;

  // Scoreboard: pops expected words on every wr_pop / rd_valid
  always @(negedge clk) begin
    logic [31:0] exp_w;
    if (done) done_cnt++;
    if (abort) abort_cnt++;
    if (wr_pop) begin
      n_checks++;
      if (wq.size() == 0) begin
        n_fail++; $display("FAIL wr_unexpected got=%h exp=none", AD_out);
      end else begin
        exp_w = wq.pop_front();
        if (AD_out !== exp_w) begin n_fail++; $display("FAIL wr_data got=%h exp=%h", AD_out, exp_w); end
      end
    end
    if (rd_valid) begin
      n_checks++;
      if (rq.size() == 0) begin
        n_fail++; $display("FAIL rd_unexpected got=%h exp=none", rd_data);
      end else begin
        exp_w = rq.pop_front();
        if (rd_data !== exp_w) begin n_fail++; $display("FAIL rd_data got=%h exp=%h", rd_data, exp_w); end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // Called on a negedge; returns on the next negedge with start dropped
  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [3:0] n);
    start = 1'b1; cmd = c; addr = a; nwords = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_checks++; if ({REQ, FRAME, IRDY, drive_en, busy} !== 5'b11100) begin n_fail++; $display("FAIL rst_ctl got=%b exp=11100", {REQ, FRAME, IRDY, drive_en, busy}); end
    n_checks++; if ({done, abort, rd_valid, wr_pop} !== 4'b0000) begin n_fail++; $display("FAIL rst_pulses got=%b exp=0000", {done, abort, rd_valid, wr_pop}); end
    n_checks++; if ({AD_out, CBE, rd_data} !== 68'd0) begin n_fail++; $display("FAIL rst_data got=%h/%h/%h exp=0", AD_out, CBE, rd_data); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_write;
    GNT = 1'b0; DEVSEL = 1'b1; TRDY = 1'b1; done_cnt = 0;
    wq.push_back(32'hCAFE_0000 + 32'(widx));
    issue(4'b0111, 32'h0000_1000, 4'd1);
    n_checks++; if (REQ !== 1'b0) begin n_fail++; $display("FAIL sw_req_fall got=%b exp=0", REQ); end
    @(negedge clk);
    n_checks++; if ({FRAME, IRDY, drive_en, REQ} !== 4'b0111) begin n_fail++; $display("FAIL sw_addr_ctl got=%b exp=0111", {FRAME, IRDY, drive_en, REQ}); end
    n_checks++; if (AD_out !== 32'h0000_1000) begin n_fail++; $display("FAIL sw_addr got=%h exp=00001000", AD_out); end
    n_checks++; if (CBE !== 4'b0111) begin n_fail++; $display("FAIL sw_cbe_cmd got=%b exp=0111", CBE); end
    DEVSEL = 1'b0; TRDY = 1'b0;
    @(negedge clk);
    n_checks++; if ({FRAME, IRDY, wr_pop} !== 3'b101) begin n_fail++; $display("FAIL sw_data_ctl got=%b exp=101", {FRAME, IRDY, wr_pop}); end
    n_checks++; if (CBE !== 4'b0000) begin n_fail++; $display("FAIL sw_cbe_data got=%b exp=0000", CBE); end
    @(negedge clk);
    n_checks++; if ({IRDY, done} !== 2'b10) begin n_fail++; $display("FAIL sw_turnar got=%b exp=10", {IRDY, done}); end
    DEVSEL = 1'b1; TRDY = 1'b1;
    @(negedge clk);
    n_checks++; if ({done, busy, drive_en} !== 3'b100) begin n_fail++; $display("FAIL sw_done got=%b exp=100", {done, busy, drive_en}); end
    @(negedge clk);
    n_checks++; if (done_cnt !== 1 || wq.size() !== 0) begin n_fail++; $display("FAIL sw_totals got=%0d/%0d exp=1/0", done_cnt, wq.size()); end
    GNT = 1'b1;
  endtask

  task automatic test_read_burst;
    int  k = 0;
    bit  waited = 1'b0;
    GNT = 1'b0; DEVSEL = 1'b1; TRDY = 1'b1; done_cnt = 0;
    issue(4'b0110, 32'h0000_2000, 4'd4);
    @(negedge clk);
    n_checks++; if ({FRAME, CBE} !== 5'b00110) begin n_fail++; $display("FAIL rb_addr got=%b exp=00110", {FRAME, CBE}); end
    DEVSEL = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (IRDY) break;
      n_checks++; if (FRAME !== (k >= 3)) begin n_fail++; $display("FAIL rb_frame k=%0d got=%b exp=%b", k, FRAME, (k >= 3)); end
      if ((k == 1 && !waited) || k >= 4) begin
        TRDY = 1'b1; waited = 1'b1;
      end else begin
        TRDY = 1'b0; AD_in = 32'hA0 + 32'(k); rq.push_back(AD_in); k++;
      end
    end
    n_checks++; if (k !== 4 || IRDY !== 1'b1) begin n_fail++; $display("FAIL rb_words got=%0d irdy=%b exp=4 irdy=1", k, IRDY); end
    TRDY = 1'b1; DEVSEL = 1'b1; AD_in = '0;
    @(negedge clk);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL rb_done got=%b exp=1", done); end
    @(negedge clk);
    n_checks++; if (done_cnt !== 1 || rq.size() !== 0 || busy !== 1'b0) begin n_fail++; $display("FAIL rb_totals got=%0d/%0d/%b exp=1/0/0", done_cnt, rq.size(), busy); end
    GNT = 1'b1;
  endtask

  task automatic test_bus_busy;
    GNT = 1'b0; bus_frame = 1'b0; bus_irdy = 1'b1; DEVSEL = 1'b0; TRDY = 1'b0; done_cnt = 0;
    wq.push_back(32'hCAFE_0000 + 32'(widx));
    wq.push_back(32'hCAFE_0000 + 32'(widx + 1));
    issue(4'b0111, 32'h0000_3000, 4'd2);
    n_checks++; if (REQ !== 1'b0) begin n_fail++; $display("FAIL bb_req got=%b exp=0", REQ); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if ({FRAME, drive_en, REQ} !== 3'b100) begin n_fail++; $display("FAIL bb_wait got=%b exp=100", {FRAME, drive_en, REQ}); end
    end
    bus_frame = 1'b1; bus_irdy = 1'b0;
    @(negedge clk);
    n_checks++; if ({FRAME, REQ} !== 2'b10) begin n_fail++; $display("FAIL bb_irdy_busy got=%b exp=10", {FRAME, REQ}); end
    bus_irdy = 1'b1;
    @(negedge clk);
    n_checks++; if (FRAME !== 1'b0 || AD_out !== 32'h0000_3000) begin n_fail++; $display("FAIL bb_addr got=%b/%h exp=0/00003000", FRAME, AD_out); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) break;
    end
    n_checks++; if (done !== 1'b1 || wq.size() !== 0) begin n_fail++; $display("FAIL bb_done got=%b/%0d exp=1/0", done, wq.size()); end
    DEVSEL = 1'b1; TRDY = 1'b1; GNT = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_master_abort;
    GNT = 1'b0; DEVSEL = 1'b1; TRDY = 1'b1; done_cnt = 0; abort_cnt = 0;
    issue(4'b0110, 32'h0000_4000, 4'd2);
    @(negedge clk);
    n_checks++; if (FRAME !== 1'b0) begin n_fail++; $display("FAIL ma_addr got=%b exp=0", FRAME); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++; if ({FRAME, IRDY} !== 2'b00) begin n_fail++; $display("FAIL ma_hold cyc=%0d got=%b exp=00", i, {FRAME, IRDY}); end
    end
    @(negedge clk);
    n_checks++; if ({FRAME, IRDY, abort} !== 3'b100) begin n_fail++; $display("FAIL ma_frame got=%b exp=100", {FRAME, IRDY, abort}); end
    @(negedge clk);
    n_checks++; if ({IRDY, abort, busy, drive_en} !== 4'b1100) begin n_fail++; $display("FAIL ma_abort got=%b exp=1100", {IRDY, abort, busy, drive_en}); end
    @(negedge clk);
    n_checks++; if (abort_cnt !== 1 || done_cnt !== 0) begin n_fail++; $display("FAIL ma_totals got=%0d/%0d exp=1/0", abort_cnt, done_cnt); end
    GNT = 1'b1;
  endtask

  task automatic test_reset_mid_burst;
    GNT = 1'b0; DEVSEL = 1'b0; TRDY = 1'b0; done_cnt = 0; abort_cnt = 0;
    issue(4'b0110, 32'h0000_5000, 4'd4);
    @(negedge clk);
    AD_in = 32'h0000_00B0;
    @(negedge clk);
    rq.push_back(AD_in);
    @(negedge clk);
    AD_in = 32'h0000_00B1;
    #2 rst = 1'b1;
    #1;
    n_checks++; if ({FRAME, IRDY, REQ, drive_en, busy} !== 5'b11100) begin n_fail++; $display("FAIL rm_async got=%b exp=11100", {FRAME, IRDY, REQ, drive_en, busy}); end
    @(negedge clk);
    rst = 1'b0; DEVSEL = 1'b1; TRDY = 1'b1; GNT = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (done_cnt !== 0 || abort_cnt !== 0 || rq.size() !== 0) begin n_fail++; $display("FAIL rm_quiet got=%0d/%0d/%0d exp=0/0/0", done_cnt, abort_cnt, rq.size()); end
    GNT = 1'b0; DEVSEL = 1'b0; TRDY = 1'b0;
    wq.push_back(32'hCAFE_0000 + 32'(widx));
    issue(4'b0111, 32'h0000_5100, 4'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) break;
    end
    n_checks++; if (done !== 1'b1 || wq.size() !== 0) begin n_fail++; $display("FAIL rm_restart got=%b/%0d exp=1/0", done, wq.size()); end
    DEVSEL = 1'b1; TRDY = 1'b1; GNT = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ignored;
    GNT = 1'b1; done_cnt = 0; abort_cnt = 0;
    issue(4'b0111, 32'h0000_6000, 4'd0);
    n_checks++; if ({REQ, busy} !== 2'b10) begin n_fail++; $display("FAIL ig_zero got=%b exp=10", {REQ, busy}); end
    issue(4'b0111, 32'h0000_6000, 4'd9);
    n_checks++; if ({REQ, busy} !== 2'b10) begin n_fail++; $display("FAIL ig_over got=%b exp=10", {REQ, busy}); end
    issue(4'b0110, 32'h0000_7000, 4'd1);
    n_checks++; if ({REQ, busy} !== 2'b01) begin n_fail++; $display("FAIL ig_valid got=%b exp=01", {REQ, busy}); end
    issue(4'b0111, 32'h0000_8000, 4'd3);
    n_checks++; if ({REQ, FRAME} !== 2'b01) begin n_fail++; $display("FAIL ig_busy_start got=%b exp=01", {REQ, FRAME}); end
    GNT = 1'b0; DEVSEL = 1'b0; TRDY = 1'b0; AD_in = 32'h0000_00C5;
    @(negedge clk);
    n_checks++; if (AD_out !== 32'h0000_7000 || CBE !== 4'b0110) begin n_fail++; $display("FAIL ig_addr got=%h/%b exp=00007000/0110", AD_out, CBE); end
    rq.push_back(32'h0000_00C5);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) break;
    end
    GNT = 1'b1; DEVSEL = 1'b1; TRDY = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (done_cnt !== 1 || abort_cnt !== 0 || rq.size() !== 0) begin n_fail++; $display("FAIL ig_totals got=%0d/%0d/%0d exp=1/0/0", done_cnt, abort_cnt, rq.size()); end
    n_checks++; if ({REQ, busy} !== 2'b10) begin n_fail++; $display("FAIL ig_no_relaunch got=%b exp=10", {REQ, busy}); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cmd = '0; addr = '0; nwords = '0;
    GNT = 1'b1; bus_frame = 1'b1; bus_irdy = 1'b1; TRDY = 1'b1; DEVSEL = 1'b1; AD_in = '0;
    test_reset();
    test_single_write();
    test_read_burst();
    test_bus_busy();
    test_master_abort();
    test_reset_mid_burst();
    test_ignored();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
